ex_mem_stage: RTL and testbench

Execute and memory-access stage that consumes the decode stage's outputs, performs the ALU operation, and runs one data-memory transaction per load or store. It feeds the results back to the decode stage's register file write ports through the EX and MEM result buses. It also drives the `stall` signal that freezes decode while a memory access is pending. It sits between the decode stage and an external data memory that uses a request/ready handshake.

---
 rtl/mips_pkg.sv | 17 +
 rtl/alu.sv | 22 ++
 rtl/ex_mem_stage.sv | 92 +++++++++
 tb/tb_ex_mem_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared control-bit indices, ALU codes, bubble control word and stage FSM states.
package mips_pkg;
  localparam int C_MEM_READ = 7;
  localparam int C_ALU_OP = 3;
  localparam int C_MEM_WRITE = 2;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  // ALUOp 111 matches neither write-back decode, so a bubble never writes the register file
  localparam logic [10:0] BUBBLE_CTRL = 11'b0_0_0_0_0_111_0_0_0;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU over the EX operands.
module alu
  import mips_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [3:0]              op,
  input  logic [SIZE-1:0]         a,
  input  logic [SIZE-1:0]         b,
  input  logic [$clog2(SIZE)-1:0] shamt,
  output logic [SIZE-1:0]         y
);
  always_comb
    y = op == ALU_AND ? a & b :
        op == ALU_OR  ? a | b :
        op == ALU_ADD ? a + b :
        op == ALU_SUB ? a - b :
        op == ALU_SLT ? SIZE'($signed(a) < $signed(b)) :
        op == ALU_NOR ? ~(a | b) :
        op == ALU_SLL ? b << shamt :
        op == ALU_SRL ? b >> shamt : '0;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline stages with a single-outstanding data-memory handshake.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [10:0]             control,
  input  logic [3:0]              ALUcontrol,
  input  logic [SIZE-1:0]         readData1,
  input  logic [SIZE-1:0]         readData2,
  input  logic [$clog2(SIZE)-1:0] shamt,
  input  logic [$clog2(SIZE)-1:0] writeReg,
  input  logic [SIZE-1:0]         PC_4,
  output logic [SIZE-1:0]         ALUresult,
  output logic [$clog2(SIZE)-1:0] writeReg_EX,
  output logic [10:0]             control_EX,
  output logic [SIZE-1:0]         ALUresult_MEM,
  output logic [$clog2(SIZE)-1:0] writeReg_MEM,
  output logic [10:0]             control_MEM,
  output logic                    stall,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [SIZE-1:0]         dmem_addr,
  output logic [SIZE-1:0]         dmem_wdata,
  input  logic                    dmem_ready,
  input  logic [SIZE-1:0]         dmem_rdata
);
  state_t state;
  logic [3:0] op_ex;
  logic [SIZE-1:0] a_ex, b_ex;
  logic [$clog2(SIZE)-1:0] sh_ex;
  logic ex_mem, adv, unused_pc;
  assign unused_pc = ^PC_4;
  assign ex_mem = control_EX[C_MEM_READ] | control_EX[C_MEM_WRITE];
  assign stall = (state == IDLE && ex_mem) || state == WAIT;
  // EX takes a new instruction whenever it is not parked on a memory op
  assign adv = state == IDLE ? !ex_mem : dmem_ready;
  alu #(.SIZE(SIZE)) u_alu (.op(op_ex), .a(a_ex), .b(b_ex), .shamt(sh_ex), .y(ALUresult));
  always_ff @(posedge clk)
    if (!rst_n) begin
      control_EX <= BUBBLE_CTRL;
      op_ex <= '0;
      a_ex <= '0;
      b_ex <= '0;
      sh_ex <= '0;
      writeReg_EX <= '0;
    end else if (adv) begin
      control_EX <= control;
      op_ex <= ALUcontrol;
      a_ex <= readData1;
      b_ex <= readData2;
      sh_ex <= shamt;
      writeReg_EX <= writeReg;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      control_MEM <= BUBBLE_CTRL;
      ALUresult_MEM <= '0;
      writeReg_MEM <= '0;
    end else if (state == IDLE) begin
      control_MEM <= ex_mem ? BUBBLE_CTRL : control_EX;
      if (!ex_mem) begin
        ALUresult_MEM <= ALUresult;
        writeReg_MEM <= writeReg_EX;
      end
    end else if (dmem_ready) begin
      control_MEM <= control_EX[C_MEM_READ] ? control_EX : BUBBLE_CTRL;
      if (control_EX[C_MEM_READ]) begin
        ALUresult_MEM <= dmem_rdata;
        writeReg_MEM <= writeReg_EX;
      end
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
    end else if (state == IDLE && ex_mem) begin
      state <= WAIT;
      dmem_req <= 1'b1;
      dmem_we <= control_EX[C_MEM_WRITE];
      dmem_addr <= ALUresult;
      dmem_wdata <= b_ex;
    end else if (state == WAIT && dmem_ready) begin
      state <= IDLE;
      dmem_req <= 1'b0;
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: randomized scoreboard bench with a reference model and a latency-varying memory.
module tb_ex_mem_stage;
  import mips_pkg::*;
  typedef struct packed {logic [10:0] ctrl; logic [3:0] op; logic [31:0] a, b; logic [4:0] sh, wr;} instr_t;
  typedef struct packed {logic [10:0] ctrl; logic [4:0] wr; logic [31:0] res;} out_t;
  typedef struct packed {logic we; logic [31:0] addr, wdata;} req_t;
  localparam instr_t BUB_I = '{ctrl: BUBBLE_CTRL, default: '0};
  localparam logic [10:0] R_CTRL = 11'b1_0_0_0_0_100_0_0_1;
  localparam logic [10:0] LW_CTRL = 11'b0_0_0_1_1_000_0_1_1;
  localparam logic [10:0] SW_CTRL = 11'b0_0_0_0_0_000_1_1_0;
  logic clk = 0, rst_n = 0;
  logic [10:0] control, control_EX, control_MEM;
  logic [3:0] ALUcontrol;
  logic [31:0] readData1, readData2, PC_4, ALUresult, ALUresult_MEM, dmem_addr, dmem_wdata;
  logic [4:0] shamt, writeReg, writeReg_EX, writeReg_MEM;
  logic stall, dmem_req, dmem_we;
  logic dmem_ready = 0;
  logic [31:0] dmem_rdata = 0;
  instr_t cur = BUB_I;
  instr_t stim_q[$];
  out_t ex_q[$], mem_q[$];
  req_t req_q[$];
  int force_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] tb_mem [logic [31:0]];
  int errors = 0, checks = 0, run = 0, cur_d = 1, wcnt = 0;
  logic took = 0, idle_ready = 0;
  req_t held, exp_r;
  out_t e;
  always #5 clk = ~clk;
  assign control = cur.ctrl;
  assign ALUcontrol = cur.op;
  assign readData1 = cur.a;
  assign readData2 = cur.b;
  assign shamt = cur.sh;
  assign writeReg = cur.wr;
  assign PC_4 = {cur.b[29:0], 2'b00};
  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .control(control), .ALUcontrol(ALUcontrol),
    .readData1(readData1), .readData2(readData2), .shamt(shamt), .writeReg(writeReg), .PC_4(PC_4),
    .ALUresult(ALUresult), .writeReg_EX(writeReg_EX), .control_EX(control_EX),
    .ALUresult_MEM(ALUresult_MEM), .writeReg_MEM(writeReg_MEM), .control_MEM(control_MEM),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected event, required none", name);
  endfunction
  function automatic logic [31:0] dflt(logic [31:0] a);
    return a * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd6: return a - b;
      4'd7: return {31'b0, $signed(a) < $signed(b)};
      4'd8: return ~(a | b);
      4'd9: return b << sh;
      4'd10: return b >> sh;
      default: return 32'b0;
    endcase
  endfunction
  function automatic void issue(instr_t i);
    logic [31:0] r = ref_alu(i.op, i.a, i.b, i.sh);
    ex_q.push_back('{i.ctrl, i.wr, r});
    if (i.ctrl[C_MEM_WRITE]) begin
      req_q.push_back('{1'b1, r, i.b});
      ref_mem[r] = i.b;
    end else if (i.ctrl[C_MEM_READ]) begin
      req_q.push_back('{1'b0, r, i.b});
      mem_q.push_back('{i.ctrl, i.wr, ref_mem.exists(r) ? ref_mem[r] : dflt(r)});
    end else if (i.ctrl != BUBBLE_CTRL)
      mem_q.push_back('{i.ctrl, i.wr, r});
  endfunction
  function automatic instr_t mk(logic [10:0] c, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh, logic [4:0] wr);
    return '{c, op, a, b, sh, wr};
  endfunction
  function automatic instr_t rnd_instr();
    instr_t i;
    int k = $urandom_range(0, 3);
    i.ctrl = 11'($urandom);
    i.ctrl[C_ALU_OP +: 3] = 3'($urandom_range(0, 6));
    i.ctrl[C_MEM_READ] = k == 1;
    i.ctrl[C_MEM_WRITE] = k == 2;
    i.op = $urandom_range(0, 9) == 0 ? 4'($urandom) : 4'($urandom_range(0, 10));
    i.a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
    i.b = $urandom_range(0, 3) == 0 ? i.a : $urandom;
    i.sh = 5'($urandom);
    i.wr = 5'($urandom);
    if (k == 1 || k == 2) begin
      i.op = ALU_AND;
      i.a = 32'h3C;
    end
    return i;
  endfunction
  // pre-edge sampling: decode advances when stall is low or the pending access completes
  always @(posedge clk) begin
    took <= rst_n && (!stall || (dmem_req && dmem_ready));
    if (!rst_n) run = 0;
    else begin
      if (!stall || (dmem_req && dmem_ready)) issue(cur);
      if (stall) run++;
      if (dmem_req && dmem_ready) begin
        chk("stall_cycles", run, 1 + cur_d);
        run = 0;
      end
    end
  end
  always @(negedge clk)
    if (!rst_n) cur = BUB_I;
    else if (took) cur = stim_q.size() != 0 ? stim_q.pop_front() : BUB_I;
  always @(negedge clk)
    if (rst_n) begin
      if (took) begin
        if (ex_q.size() == 0) fail("ex_unexpected");
        else begin
          e = ex_q.pop_front();
          chk("ex_result", ALUresult, e.res);
          chk("ex_wreg", 32'(writeReg_EX), 32'(e.wr));
          chk("ex_ctrl", 32'(control_EX), 32'(e.ctrl));
        end
      end
      if (control_MEM !== BUBBLE_CTRL) begin
        if (mem_q.size() == 0) fail("mem_unexpected");
        else begin
          e = mem_q.pop_front();
          chk("mem_result", ALUresult_MEM, e.res);
          chk("mem_wreg", 32'(writeReg_MEM), 32'(e.wr));
          chk("mem_ctrl", 32'(control_MEM), 32'(e.ctrl));
        end
      end
    end
  always @(negedge clk)
    if (!rst_n || !dmem_req) begin
      wcnt = 0;
      dmem_ready = idle_ready | 1'($urandom);
      dmem_rdata = $urandom;
    end else begin
      if (wcnt == 0) begin
        cur_d = force_q.size() != 0 ? force_q.pop_front() : int'($urandom_range(1, 3));
        held = '{dmem_we, dmem_addr, dmem_wdata};
        if (req_q.size() == 0) fail("dmem_unexpected");
        else begin
          exp_r = req_q.pop_front();
          chk("dmem_we", 32'(dmem_we), 32'(exp_r.we));
          chk("dmem_addr", dmem_addr, exp_r.addr);
          chk("dmem_wdata", dmem_wdata, exp_r.wdata);
        end
      end else begin
        chk("dmem_we_stable", 32'(dmem_we), 32'(held.we));
        chk("dmem_addr_stable", dmem_addr, held.addr);
        chk("dmem_wdata_stable", dmem_wdata, held.wdata);
      end
      wcnt++;
      dmem_ready = wcnt == cur_d;
      dmem_rdata = $urandom;
      if (dmem_ready && dmem_we) tb_mem[dmem_addr] = dmem_wdata;
      else if (dmem_ready) dmem_rdata = tb_mem.exists(dmem_addr) ? tb_mem[dmem_addr] : dflt(dmem_addr);
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    tb_mem[32'h40] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_control_EX", 32'(control_EX), 32'(BUBBLE_CTRL));
    chk("rst_control_MEM", 32'(control_MEM), 32'(BUBBLE_CTRL));
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_result_MEM", ALUresult_MEM, 32'd0);
    rst_n = 1;
    stim_q.push_back(mk(R_CTRL, ALU_ADD, 32'd5, 32'd7, 5'd0, 5'd3));
    stim_q.push_back(mk(R_CTRL, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd4));
    stim_q.push_back(mk(R_CTRL, ALU_SLL, 32'd0, 32'h8000_0001, 5'd1, 5'd5));
    stim_q.push_back(mk(R_CTRL, ALU_SRL, 32'd0, 32'h8000_0001, 5'd1, 5'd6));
    force_q.push_back(3);
    stim_q.push_back(mk(LW_CTRL, ALU_AND, 32'hFFFF_FFFF, 32'h40, 5'd0, 5'd8));
    stim_q.push_back(mk(R_CTRL, ALU_SUB, 32'd3, 32'd10, 5'd0, 5'd9));
    stim_q.push_back(mk(SW_CTRL, ALU_AND, 32'h80, 32'h1234_5680, 5'd0, 5'd0));
    stim_q.push_back(mk(LW_CTRL, ALU_AND, 32'hFFFF_FFFF, 32'h80, 5'd0, 5'd10));
    repeat (300) stim_q.push_back(rnd_instr());
    for (int n = 0; n < 5000 && (stim_q.size() != 0 || mem_q.size() != 0 || cur.ctrl != BUBBLE_CTRL); n++)
      @(negedge clk);
    repeat (8) @(negedge clk);
    chk("drain_mem_q", mem_q.size(), 32'd0);
    chk("drain_req_q", req_q.size(), 32'd0);
    force_q.push_back(20);
    stim_q.push_back(mk(LW_CTRL, ALU_AND, 32'hFFFF_FFFF, 32'h40, 5'd0, 5'd7));
    for (int n = 0; n < 50 && !dmem_req; n++) @(negedge clk);
    chk("abort_req_seen", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("abort_dmem_req", 32'(dmem_req), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_control_EX", 32'(control_EX), 32'(BUBBLE_CTRL));
    chk("abort_control_MEM", 32'(control_MEM), 32'(BUBBLE_CTRL));
    mem_q.delete();
    idle_ready = 1;
    @(negedge clk);
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("ignored_ready_req", 32'(dmem_req), 32'd0);
      chk("ignored_ready_stall", 32'(stall), 32'd0);
    end
    chk("final_mem_q", mem_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
